// File: rtl/alu_op_sequencer.sv
// Round-robin sequencer sharing one combinational 8-bit ALU between two requesters.
// Optional macro ALU_SEQ_ILLEGAL_OP_EN: opcodes 100..111 are not issued and return RSP_ERR=1.
module alu_op_sequencer #(
    parameter int DATA_W    = 8,
    parameter int ADD_LAT   = 2,
    parameter int LOGIC_LAT = 1
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              REQ0_VALID,
    output logic              REQ0_READY,
    input  logic [2:0]        REQ0_OP,
    input  logic [DATA_W-1:0] REQ0_A,
    input  logic [DATA_W-1:0] REQ0_B,
    input  logic              REQ1_VALID,
    output logic              REQ1_READY,
    input  logic [2:0]        REQ1_OP,
    input  logic [DATA_W-1:0] REQ1_A,
    input  logic [DATA_W-1:0] REQ1_B,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic              RSP_ID,
    output logic [DATA_W-1:0] RSP_DATA,
    output logic              RSP_ERR,
    output logic [DATA_W-1:0] ALU_DATA1,
    output logic [DATA_W-1:0] ALU_DATA2,
    output logic [2:0]        ALU_SELECT,
    input  logic [DATA_W-1:0] ALU_RESULT
);

    localparam int MAX_LAT = (ADD_LAT > LOGIC_LAT) ? ADD_LAT : LOGIC_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pointer_q, pointer_d;
    logic               id_q, id_d;
    logic               illegal_q, illegal_d;
    logic               rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]  data1_q, data1_d;
    logic [DATA_W-1:0]  data2_q, data2_d;
    logic [2:0]         select_q, select_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;

    logic               grant;
    logic               accept;
    logic               grant_illegal;
    logic [2:0]         grant_op;
    logic [DATA_W-1:0]  grant_a;
    logic [DATA_W-1:0]  grant_b;

    function automatic logic [CNT_W-1:0] lat_of(input logic [2:0] op);
        return (op == 3'b001) ? CNT_W'(ADD_LAT) : CNT_W'(LOGIC_LAT);
    endfunction

    // Pointer side wins when valid; otherwise the other side is granted.
    always_comb begin
        grant = pointer_q;
        if (pointer_q) begin
            grant = REQ1_VALID ? 1'b1 : 1'b0;
        end else begin
            grant = REQ0_VALID ? 1'b0 : 1'b1;
        end
        accept   = (state_q == ST_IDLE) && (REQ0_VALID || REQ1_VALID) && RESET_N;
        grant_op = grant ? REQ1_OP : REQ0_OP;
        grant_a  = grant ? REQ1_A  : REQ0_A;
        grant_b  = grant ? REQ1_B  : REQ0_B;
`ifdef ALU_SEQ_ILLEGAL_OP_EN
        grant_illegal = grant_op[2];
`else
        grant_illegal = 1'b0;
`endif
    end

    assign REQ0_READY = accept && !grant;
    assign REQ1_READY = accept && grant;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pointer_d  = pointer_q;
        id_d       = id_q;
        illegal_d  = illegal_q;
        rsp_err_d  = rsp_err_q;
        data1_d    = data1_q;
        data2_d    = data2_q;
        select_d   = select_q;
        rsp_data_d = rsp_data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    id_d      = grant;
                    pointer_d = ~grant;
                    state_d   = ST_EXEC;
                    // Illegal ops leave the ALU operands untouched and finish after one cycle.
                    if (grant_illegal) begin
                        illegal_d = 1'b1;
                        cnt_d     = CNT_W'(1);
                    end else begin
                        illegal_d = 1'b0;
                        data1_d   = grant_a;
                        data2_d   = grant_b;
                        select_d  = grant_op;
                        cnt_d     = lat_of(grant_op);
                    end
                end
            end
            ST_EXEC: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d    = ST_RESP;
                    rsp_data_d = illegal_q ? '0 : ALU_RESULT;
                    rsp_err_d  = illegal_q;
                end
            end
            ST_RESP: begin
                if (RSP_READY) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            pointer_q  <= 1'b0;
            id_q       <= 1'b0;
            illegal_q  <= 1'b0;
            rsp_err_q  <= 1'b0;
            data1_q    <= '0;
            data2_q    <= '0;
            select_q   <= 3'b000;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pointer_q  <= pointer_d;
            id_q       <= id_d;
            illegal_q  <= illegal_d;
            rsp_err_q  <= rsp_err_d;
            data1_q    <= data1_d;
            data2_q    <= data2_d;
            select_q   <= select_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign RSP_VALID  = (state_q == ST_RESP);
    assign RSP_ID     = id_q;
    assign RSP_DATA   = rsp_data_q;
    assign RSP_ERR    = rsp_err_q;
    assign ALU_DATA1  = data1_q;
    assign ALU_DATA2  = data2_q;
    assign ALU_SELECT = select_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: directed ops push expected responses,
// a negedge monitor pops and compares them on every response handshake.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0] req0_op, req1_op;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [7:0] rsp_data;
    logic [7:0] alu_data1, alu_data2, alu_result;
    logic [2:0] alu_select;

    typedef struct packed {
        logic       id;
        logic [7:0] data;
        logic       err;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_exp;
    int   vectors     = 0;
    int   miscompares = 0;

    alu_op_sequencer #(.DATA_W(8), .ADD_LAT(2), .LOGIC_LAT(1)) dut (
        .CLK(clk), .RESET_N(rst_n),
        .REQ0_VALID(req0_valid), .REQ0_READY(req0_ready), .REQ0_OP(req0_op),
        .REQ0_A(req0_a), .REQ0_B(req0_b),
        .REQ1_VALID(req1_valid), .REQ1_READY(req1_ready), .REQ1_OP(req1_op),
        .REQ1_A(req1_a), .REQ1_B(req1_b),
        .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_ID(rsp_id),
        .RSP_DATA(rsp_data), .RSP_ERR(rsp_err),
        .ALU_DATA1(alu_data1), .ALU_DATA2(alu_data2), .ALU_SELECT(alu_select),
        .ALU_RESULT(alu_result)
    );

    always #5 clk = ~clk;

    // Reference ALU: FORWARD passes DATA1.
    always_comb begin
        case (alu_select)
            3'b000:  alu_result = alu_data1;
            3'b001:  alu_result = alu_data1 + alu_data2;
            3'b010:  alu_result = alu_data1 & alu_data2;
            3'b011:  alu_result = alu_data1 | alu_data2;
            default: alu_result = 8'h00;
        endcase
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_rsp", rsp_valid, 1'b0);
            end else begin
                mon_exp = exp_q.pop_front();
                check_output("rsp_id", rsp_id, mon_exp.id);
                check_output("rsp_data", rsp_data, mon_exp.data);
                check_output("rsp_err", rsp_err, mon_exp.err);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rsp(input logic id, input logic [7:0] data);
        exp_q.push_back({id, data, 1'b0});
    endtask

    task automatic drive(input logic id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        if (id) begin
            req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
        end else begin
            req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
        end
    endtask

    task automatic wait_rsp(input int exp_lat, input string name);
        int cycles = 0;
        while (!rsp_valid && cycles < 40) begin
            tick();
            cycles++;
        end
        check_output(name, cycles, exp_lat);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (rsp_valid && n < 40) begin
            tick();
            n++;
        end
        check_output(name, rsp_valid, 1'b0);
    endtask

    task automatic apply_stimulus(input logic id, input logic [2:0] op, input logic [7:0] a,
                                  input logic [7:0] b, input logic [7:0] exp_data,
                                  input int exp_lat, input string name);
        int n = 0;
        drive(id, op, a, b);
        #1;
        while (!(id ? req1_ready : req0_ready) && n < 40) begin
            tick();
            n++;
        end
        check_output({name, "_ready"}, id ? req1_ready : req0_ready, 1'b1);
        expect_rsp(id, exp_data);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check_output({name, "_select"}, alu_select, op);
        check_output({name, "_data1"}, alu_data1, a);
        check_output({name, "_data2"}, alu_data2, b);
        wait_rsp(exp_lat, {name, "_lat"});
        drain({name, "_drain"});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic seen;
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = 3'b000; req0_a = 8'h00; req0_b = 8'h00;
        req1_op = 3'b000; req1_a = 8'h00; req1_b = 8'h00;

        // Reset with both requesters asserting.
        drive(1'b0, 3'b001, 8'h11, 8'h22);
        drive(1'b1, 3'b011, 8'h33, 8'h44);
        #2;
        check_output("rst_ready0", req0_ready, 1'b0);
        check_output("rst_ready1", req1_ready, 1'b0);
        check_output("rst_rsp_valid", rsp_valid, 1'b0);
        check_output("rst_select", alu_select, 3'b000);
        check_output("rst_data1", alu_data1, 8'h00);
        check_output("rst_data2", alu_data2, 8'h00);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ADD then a lone requester served back-to-back.
        apply_stimulus(1'b0, 3'b001, 8'h05, 8'h03, 8'h08, 2, "add");
        apply_stimulus(1'b0, 3'b000, 8'h3C, 8'h00, 8'h3C, 1, "fwd0");
        apply_stimulus(1'b0, 3'b001, 8'hF0, 8'h20, 8'h10, 2, "add_wrap");

        // Both valid after reset: requester 0 first, then 1.
        do_reset();
        drive(1'b0, 3'b010, 8'hF0, 8'h3C);
        drive(1'b1, 3'b011, 8'h30, 8'h0C);
        #1;
        check_output("both_ready0", req0_ready, 1'b1);
        check_output("both_ready1", req1_ready, 1'b0);
        expect_rsp(1'b0, 8'h30);
        expect_rsp(1'b1, 8'h3C);
        tick();
        req0_valid = 1'b0;
        check_output("and_select", alu_select, 3'b010);
        check_output("exec_ready1", req1_ready, 1'b0);
        wait_rsp(1, "and_lat");
        check_output("resp_ready1", req1_ready, 1'b0);
        drain("and_drain");
        check_output("second_ready1", req1_ready, 1'b1);
        tick();
        req1_valid = 1'b0;
        check_output("or_select", alu_select, 3'b011);
        wait_rsp(1, "or_lat");
        drain("or_drain");

        // Stalled response stays stable and blocks both requesters.
        rsp_ready = 1'b0;
        drive(1'b1, 3'b000, 8'hA5, 8'hA5);
        #1;
        check_output("fwd1_ready", req1_ready, 1'b1);
        expect_rsp(1'b1, 8'hA5);
        tick();
        req1_valid = 1'b0;
        wait_rsp(1, "fwd1_lat");
        drive(1'b0, 3'b001, 8'h10, 8'h20);
        for (int i = 0; i < 5; i++) begin
            check_output("stall_valid", rsp_valid, 1'b1);
            check_output("stall_data", rsp_data, 8'hA5);
            check_output("stall_id", rsp_id, 1'b1);
            check_output("stall_ready0", req0_ready, 1'b0);
            check_output("stall_ready1", req1_ready, 1'b0);
            tick();
        end
        rsp_ready = 1'b1;
        expect_rsp(1'b0, 8'h30);
        drain("stall_drain");
        check_output("after_stall_ready0", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        wait_rsp(2, "after_stall_lat");
        drain("after_stall_drain");

        // Reset in the middle of an ADD discards it.
        drive(1'b0, 3'b001, 8'h07, 8'h09);
        #1;
        check_output("abort_ready0", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        check_output("abort_select", alu_select, 3'b000);
        check_output("abort_rsp_valid", rsp_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen = seen | rsp_valid;
        end
        check_output("abort_no_rsp", seen, 1'b0);
        apply_stimulus(1'b1, 3'b011, 8'h81, 8'h42, 8'hC3, 1, "or1");
        drive(1'b0, 3'b010, 8'hFF, 8'h0F);
        drive(1'b1, 3'b001, 8'h01, 8'hFF);
        #1;
        check_output("post_rst_ready0", req0_ready, 1'b1);
        check_output("post_rst_ready1", req1_ready, 1'b0);
        expect_rsp(1'b0, 8'h0F);
        expect_rsp(1'b1, 8'h00);
        tick();
        req0_valid = 1'b0;
        wait_rsp(1, "post_and_lat");
        drain("post_and_drain");
        check_output("post_ready1", req1_ready, 1'b1);
        tick();
        req1_valid = 1'b0;
        wait_rsp(2, "post_add_lat");
        drain("post_add_drain");

        repeat (3) tick();
        check_output("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
